// File: rtl/vid_line_packer.sv
// Packs retimed video pixels four per 64-bit word into ping-pong line buffers and flags completed lines.
// Optional CAMERICA_TEST_PATTERN_EN replaces vid_pixel with a {line, column} test pattern.
module vid_line_packer #(
   parameter int WORD_AW = 8,
   parameter int PIX_W   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   vid_pixel,
   input  logic               vid_pixsync,
   input  logic               vid_hsync,
   input  logic               vid_vsync,
   input  logic               vid_visible,
   input  logic               vid_locked,
   output logic               buf_wr_en,
   output logic [WORD_AW:0]   buf_wr_addr,
   output logic [63:0]        buf_wr_data,
   output logic               rd_bank,
   output logic               line_done,
   output logic [WORD_AW:0]   line_words,
   output logic [15:0]        line_num,
   output logic               frame_start,
   output logic               overflow,
   input  logic               ovf_clr
);

   typedef enum logic [1:0] {WAIT_LOCK, WAIT_FRAME, ACTIVE} state_t;

   state_t state, state_nxt;
   logic   in_wait_frame, in_active;

   logic [1:0]       pack_cnt;
   logic [47:0]      pack_reg;
   logic [WORD_AW:0] word_idx;
   logic             cur_bank;
   logic [15:0]      line_cnt;

   logic             close_pend;
   logic [WORD_AW:0] cap_words;
   logic [15:0]      cap_num;
   logic             cap_bank;

   logic             start_frame, close_line, new_line;
   logic             pix_ok, accept, drop;
   logic [WORD_AW:0] eff_idx;
   logic [1:0]       eff_cnt;
   logic [47:0]      eff_pack, pack_ins;
   logic [PIX_W-1:0] pix_src;
   logic [15:0]      pix16;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst) state <= WAIT_LOCK;
      else      state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOCK:  if (vid_locked) state_nxt = WAIT_FRAME;
         WAIT_FRAME: if (vid_vsync)  state_nxt = ACTIVE;
         default:    state_nxt = ACTIVE;
      endcase
      if (!vid_locked) state_nxt = WAIT_LOCK;
   end

   // FSM: state decode
   always_comb begin
      in_wait_frame = (state == WAIT_FRAME);
      in_active     = (state == ACTIVE);
   end

   always_comb begin
      start_frame = in_wait_frame & vid_vsync & vid_locked;
      close_line  = in_active & (vid_hsync | vid_vsync) & vid_locked;
      new_line    = start_frame | close_line;
      // a pixel coincident with a sync strobe is pixel 0 of the new line
      eff_idx     = new_line ? '0 : word_idx;
      eff_cnt     = new_line ? 2'd0 : pack_cnt;
      eff_pack    = new_line ? '0 : pack_reg;
      pix_ok      = vid_pixsync & vid_visible & vid_locked & (in_active | start_frame);
      accept      = pix_ok & ~eff_idx[WORD_AW];
      drop        = pix_ok & eff_idx[WORD_AW];
   end

`ifdef CAMERICA_TEST_PATTERN_EN
   logic [15:0]      line_eff;
   logic [WORD_AW+2:0] col_full;
   logic [11:0]      pat;

   always_comb begin
      if (start_frame || (close_line && vid_vsync)) line_eff = '0;
      else if (close_line)                          line_eff = line_cnt + 16'd1;
      else                                          line_eff = line_cnt;
      col_full = {eff_idx, eff_cnt};
      pat      = {line_eff[3:0], 8'(col_full)};
      pix_src  = PIX_W'(pat);
   end
`else
   always_comb pix_src = vid_pixel;
`endif

   always_comb begin
      pix16    = 16'(pix_src);
      pack_ins = eff_pack;
      case (eff_cnt)
         2'd0:    pack_ins[15:0]  = pix16;
         2'd1:    pack_ins[31:16] = pix16;
         default: pack_ins[47:32] = pix16;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pack_cnt    <= '0;
         pack_reg    <= '0;
         word_idx    <= '0;
         cur_bank    <= 1'b0;
         line_cnt    <= '0;
         close_pend  <= 1'b0;
         cap_words   <= '0;
         cap_num     <= '0;
         cap_bank    <= 1'b0;
         buf_wr_en   <= 1'b0;
         buf_wr_addr <= '0;
         buf_wr_data <= '0;
         rd_bank     <= 1'b1;
         line_done   <= 1'b0;
         line_words  <= '0;
         line_num    <= '0;
         frame_start <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         buf_wr_en   <= 1'b0;
         line_done   <= 1'b0;
         frame_start <= start_frame | (close_line & vid_vsync);
         close_pend  <= close_line;

         // second close stage: publish the finished line and hand its bank to the reader
         if (close_pend) begin
            line_done  <= 1'b1;
            line_words <= cap_words;
            line_num   <= cap_num;
            rd_bank    <= cap_bank;
         end

         if (start_frame) line_cnt <= '0;

         if (close_line) begin
            cap_words <= word_idx + (WORD_AW+1)'(pack_cnt != 2'd0);
            cap_num   <= line_cnt;
            cap_bank  <= cur_bank;
            cur_bank  <= ~cur_bank;
            line_cnt  <= vid_vsync ? 16'd0 : line_cnt + 16'd1;
            if (pack_cnt != 2'd0) begin
               buf_wr_en   <= 1'b1;
               buf_wr_addr <= {cur_bank, word_idx[WORD_AW-1:0]};
               buf_wr_data <= {16'h0000, pack_reg};
            end
         end

         if (!vid_locked) begin
            pack_cnt <= '0;
            pack_reg <= '0;
            word_idx <= '0;
         end else if (accept) begin
            if (eff_cnt == 2'd3) begin
               buf_wr_en   <= 1'b1;
               buf_wr_addr <= {cur_bank, eff_idx[WORD_AW-1:0]};
               buf_wr_data <= {pix16, eff_pack};
               pack_cnt    <= '0;
               pack_reg    <= '0;
               word_idx    <= eff_idx + 1'b1;
            end else begin
               pack_cnt <= eff_cnt + 2'd1;
               pack_reg <= pack_ins;
               word_idx <= eff_idx;
            end
         end else if (new_line) begin
            pack_cnt <= '0;
            pack_reg <= '0;
            word_idx <= '0;
         end

         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule
